// File: rtl/uc_seq_pkg.sv
// Shared definitions for the microc control unit: opcode constants,
// FSM state encoding and the packed control-word layout.
package uc_seq_pkg;

    // Upper three opcode bits that mark an ALU-class instruction.
    localparam logic [2:0] ALU_PFX = 3'b000;

    localparam logic [5:0] OP_LI   = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_HALT = 6'b011111;
    localparam logic [5:0] OP_NOP  = 6'b111111;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // Control word driven back to the datapath.
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } ctrl_t;

    // Sequential fetch, no architectural writes.
    localparam ctrl_t CTRL_IDLE  = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: 3'b000};
    // PC held on the self-looping HALT address, no architectural writes.
    localparam ctrl_t CTRL_STALL = '{s_inc: 1'b0, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: 3'b000};

endpackage

// File: rtl/uc_seq_dec.sv
// Pure combinational instruction decoder: Opcode and zero flag to control
// word, plus HALT and undefined-opcode indications for the sequencer.
module uc_seq_dec
    import uc_seq_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic       i_z,
    output ctrl_t      o_ctrl,
    output logic       o_is_halt,
    output logic       o_is_illegal
);

    // Decode one instruction; anything not listed behaves as a NOP and is flagged.
    always_comb begin
        o_ctrl       = CTRL_IDLE;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;
        if (i_opcode[5:3] == ALU_PFX) begin
            o_ctrl.op  = i_opcode[2:0];
            o_ctrl.we3 = 1'b1;
            o_ctrl.wez = 1'b1;
        end else begin
            case (i_opcode)
                OP_LI: begin
                    o_ctrl.we3   = 1'b1;
                    o_ctrl.s_inm = 1'b1;
                end
                OP_J:    o_ctrl.s_inc = 1'b0;
                OP_JZ:   o_ctrl.s_inc = ~i_z;
                OP_JNZ:  o_ctrl.s_inc = i_z;
                OP_HALT: begin
                    o_ctrl.s_inc = 1'b0;
                    o_is_halt    = 1'b1;
                end
                OP_NOP:  o_ctrl = CTRL_IDLE;
                default: o_is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc_seq.sv
// Control unit for the single-cycle microc datapath. Control outputs are
// combinational from (state, Opcode, z); a RUN/HALT FSM, a sticky
// illegal-opcode flag and a saturating retired-instruction counter are
// kept for debug.
module uc_seq
    import uc_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    ctrl_t w_dec_ctrl;
    ctrl_t w_ctrl;
    logic  w_is_halt;
    logic  w_is_illegal;

    uc_seq_dec u_dec (
        .i_opcode     (Opcode),
        .i_z          (z),
        .o_ctrl       (w_dec_ctrl),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    // Reset blocks writes first; HALT then pins the PC regardless of what is fetched.
    always_comb begin
        w_ctrl = w_dec_ctrl;
        if (reset) begin
            w_ctrl = CTRL_IDLE;
        end else if (r_state == S_HALT) begin
            w_ctrl = CTRL_STALL;
        end
    end

    assign s_inc   = w_ctrl.s_inc;
    assign s_inm   = w_ctrl.s_inm;
    assign we3     = w_ctrl.we3;
    assign wez     = w_ctrl.wez;
    assign Op      = w_ctrl.op;
    assign halted  = (r_state == S_HALT);
    assign illegal = r_illegal;
    assign retired = r_retired;

    // RUN/HALT state, sticky illegal flag and saturating count; all only advance while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else if (r_state == S_RUN) begin
            if (r_retired != {CNT_W{1'b1}}) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_is_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_is_halt) begin
                r_state <= S_HALT;
            end
        end
    end

endmodule
